// File: rtl/weight_rom_stream_scheduler.sv
// Streams a fixed-latency parameter ROM as a valid/ready beat stream, repeated a programmable
// number of passes, with a small first-word-fall-through buffer that absorbs consumer backpressure.
module weight_rom_stream_scheduler #(
    parameter int DATA_WIDTH  = 128,
    parameter int OUT_DEPTH   = 32,
    parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int PASS_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_address0,
    output logic                  rom_ce0,
    input  logic [DATA_WIDTH-1:0] rom_q0,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUT_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_FINISH} state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [PASS_WIDTH-1:0]   r_pass_cnt;
    logic [PASS_WIDTH-1:0]   r_num_passes;
    logic [ROM_LATENCY-1:0]  r_tags;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_count;

    logic                    w_pop;
    logic                    w_push;
    logic                    w_issue;
    logic                    w_last_issue;
    logic                    w_drained;
    logic [CNT_W-1:0]        w_inflight;
    logic [CNT_W-1:0]        w_count_nxt;
    logic [ROM_LATENCY-1:0]  w_tags_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_tags[i]);
        end
    end

    assign w_pop  = (r_count != '0) && data_out_ready;
    assign w_push = r_tags[ROM_LATENCY-1];

    // Reserve a buffer slot for every read in flight so a returning word always has room.
    assign w_issue = (r_state == S_STREAM) &&
                     ((r_count + w_inflight - CNT_W'(w_pop)) < CNT_W'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_addr == LAST_ADDR) &&
                          (r_pass_cnt == r_num_passes - PASS_WIDTH'(1));

    assign w_tags_nxt  = (r_tags << 1) | ROM_LATENCY'(w_issue);
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // Looking at next-cycle occupancy lets done follow the last handshake directly.
    assign w_drained   = (w_count_nxt == '0) && (w_tags_nxt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_pass_cnt   <= '0;
            r_num_passes <= '0;
            r_tags       <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_tags  <= w_tags_nxt;
            r_count <= w_count_nxt;
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);

            if (w_issue) begin
                if (r_addr == LAST_ADDR) begin
                    r_addr     <= '0;
                    r_pass_cnt <= r_pass_cnt + PASS_WIDTH'(1);
                end else begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_passes <= num_passes;
                        r_addr       <= '0;
                        r_pass_cnt   <= '0;
                        r_state      <= (num_passes == '0) ? S_FINISH : S_STREAM;
                    end
                end
                S_STREAM: if (w_last_issue) r_state <= S_DRAIN;
                S_DRAIN:  if (w_drained)    r_state <= S_FINISH;
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: buffer storage carries no reset; r_count gates validity, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= rom_q0;
    end

    assign data_out       = r_mem[r_rd_ptr];
    assign data_out_valid = (r_count != '0);
    assign rom_address0   = r_addr;
    assign rom_ce0        = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_FINISH);

endmodule

// File: doc/weight_rom_stream_scheduler.md
# weight_rom_stream_scheduler

Sequences a two-cycle-latency parameter ROM so that its contents are streamed as a fully handshaken valid/ready beat stream, repeated a programmable number of passes. It sits between a parameter ROM wrapper and the consuming linear/matmul datapath. Unlike a free-running weight source, it honours `data_out_ready` without dropping or duplicating words. It also reports `busy` and `done` to the layer controller.

## Interface
- `DATA_WIDTH`, 128: bits per ROM word and per output beat.
- `OUT_DEPTH`, 32: ROM words per pass, ≥ 1.
- `ADDR_WIDTH`, `$clog2(OUT_DEPTH)+1`: ROM address width.
- `ROM_LATENCY`, 2: cycles from address to `rom_q0`. Fixed pipeline.
- `FIFO_DEPTH`, 4: output buffer entries, ≥ `ROM_LATENCY`+2.
- `PASS_WIDTH`, 16: width of the pass count.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a job; sampled only in IDLE.
- `num_passes` in `PASS_WIDTH`: passes over the ROM; captured when `start` is accepted.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the job completes.
- `rom_address0` out `ADDR_WIDTH`: ROM read address.
- `rom_ce0` out 1: ROM clock enable.
- `rom_q0` in `DATA_WIDTH`: ROM read data.
- `data_out` out `DATA_WIDTH`: head of the output FIFO.
- `data_out_valid` out 1: the FIFO is non-empty.
- `data_out_ready` in 1: the consumer accepts the beat.

## Operation
- FSM states are IDLE, STREAM, DRAIN and FINISH.
- IDLE → STREAM: `start`=1 and `num_passes`≠0. The block captures `num_passes` and clears `addr` and `pass_cnt`.
- IDLE → FINISH: `start`=1 and `num_passes`=0. No ROM reads are issued.
- STREAM, issue condition: a read is issued in any cycle where `fifo_count` + `inflight` − `pop` < `FIFO_DEPTH`. `pop` = `data_out_valid` & `data_out_ready`.
- STREAM, on issue: `rom_address0` = `addr`. `addr` increments and wraps from `OUT_DEPTH`−1 to 0. On each wrap, `pass_cnt` increments.
- STREAM → DRAIN: the issue of `addr`=`OUT_DEPTH`−1 in the final pass.
- DRAIN: no further issues. Waits until `inflight`=0 and the FIFO is empty.
- DRAIN → FINISH: `inflight`=0 and FIFO empty.
- FINISH: `done`=1 for exactly this cycle, then → IDLE.
- In-flight tracking: an `ROM_LATENCY`-bit shift register tags each issued read. When a tag exits, `rom_q0` is pushed into the FIFO in that same cycle.
- FIFO:
  - Synchronous, first-word-fall-through.
  - Push and pop may occur in the same cycle, including when the FIFO is full.
  - By construction of the issue rule, a push never occurs while the FIFO is full and not popping.
- `rom_ce0` = 1 in STREAM and DRAIN, 0 otherwise. The ROM pipeline therefore never stalls while tags are in flight.
- A `start` pulse while `busy` is ignored.
- `data_out` is meaningful only while `data_out_valid`=1.

## Timing
- Reset values: `busy`=0, `done`=0, `data_out_valid`=0, `rom_ce0`=0, `rom_address0`=0. FIFO and in-flight tags are cleared; state is IDLE.
- Reset mid-job: all in-flight reads are discarded, and every output returns to its reset value in the cycle after `rst` is sampled.
- Reference timeline, with `start` high in cycle 0:
  - Cycle 1: STREAM; address 0 issued.
  - Cycle 3: `rom_q0` holds word 0 and is pushed.
  - Cycle 4: `data_out_valid` rises.
  - Latency from `start` to first valid beat is 4 cycles.
- Throughput: with `data_out_ready` held at 1, one beat per cycle with no bubbles, including across pass boundaries.
- Backpressure: `data_out` and `data_out_valid` hold steady while `data_out_valid`=1 and `data_out_ready`=0.
- Occupancy bound: `fifo_count` + `inflight` ≤ `FIFO_DEPTH` at all times.
- Completion: `done` is asserted in the cycle after the last beat's handshake. `busy` drops in the following cycle.
- Zero passes: `start` in cycle 0 gives `done`=1 in cycle 1. No `rom_ce0` activity and no beats.
- Beat order: exactly `OUT_DEPTH`×`num_passes` beats are emitted per job, in address order 0…`OUT_DEPTH`−1 repeated.

## Test plan
- Streaming, ready always high:
  - Stimulus: `OUT_DEPTH`=4, ROM word i = i, `num_passes`=2, `data_out_ready`=1, `start` in cycle 0.
  - Response: beats 0,1,2,3,0,1,2,3 in cycles 4–11; `done` in cycle 12; `busy` low from cycle 13.
- Random backpressure:
  - Stimulus: `OUT_DEPTH`=32, `num_passes`=3, `data_out_ready` random at 50%.
  - Response: 96 beats in order; no loss or duplication; `data_out` stable while stalled; `fifo_count` never exceeds 4.
- Stall then release:
  - Stimulus: `data_out_ready`=0 for 20 cycles after `start`, then 1.
  - Response: exactly 4 words are buffered and the issue stops; after release, beats 0,1,2,3,4… are emitted back-to-back.
- Zero passes:
  - Stimulus: `num_passes`=0 with `start`.
  - Response: `done` in cycle 1; `rom_ce0` stays 0; no valid beats.
- Start while busy:
  - Stimulus: a second `start` pulse with `num_passes`=5 during a 1-pass job.
  - Response: it is ignored; the job emits exactly `OUT_DEPTH` beats and a single `done` pulse.
- Reset mid-job:
  - Stimulus: `rst` asserted in cycle 7 of a 2-pass job, then a new `start`.
  - Response: outputs reach reset values in cycle 8; the new job restarts at address 0 with the full 4-cycle latency.
